// File: rtl/csr_access_ctrl_pkg.sv
// rtl/csr_access_ctrl_pkg.sv - CSR addresses, mstatus bit positions and sequencer states
package csr_access_ctrl_pkg;

  localparam int MAX_BIT_POS = 31;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T_EPC    = 3'd1,
    ST_T_CAUSE  = 3'd2,
    ST_T_TVAL   = 3'd3,
    ST_T_STATUS = 3'd4,
    ST_M_STATUS = 3'd5
  } state_e;

  typedef enum logic {
    UPD_TRAP = 1'b0,
    UPD_MRET = 1'b1
  } upd_mode_e;

endpackage

// File: rtl/csr_mstatus_upd.sv
// rtl/csr_mstatus_upd.sv - combinational mstatus update for trap entry and mret
module csr_mstatus_upd
  import csr_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus,
  input  upd_mode_e       mode,
  output logic [XLEN-1:0] mstatus_upd
);

  always_comb begin
    mstatus_upd = mstatus;
    mstatus_upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (mode == UPD_TRAP) begin
      mstatus_upd[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_upd[MSTATUS_MIE]  = 1'b0;
    end else begin
      mstatus_upd[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_upd[MSTATUS_MPIE] = 1'b1;
    end
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - CSR write-port arbiter and trap/mret sequencer; CSR_TVAL_EN adds the mtval write
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int XLEN            = MAX_BIT_POS + 1,
  parameter int MTVEC_MODE_MASK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_csr_we,
  input  logic [11:0]     ex_csr_waddr,
  input  logic [XLEN-1:0] ex_csr_wdata,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  output logic            trap_ack,
  input  logic            mret_req,
  output logic            mret_ack,
  input  logic [XLEN-1:0] mstatus_rdata,
  input  logic [XLEN-1:0] mtvec_rdata,
  input  logic [XLEN-1:0] mepc_rdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            ex_stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] MTVEC_KEEP =
    ~((XLEN'(1) << MTVEC_MODE_MASK) - XLEN'(1));

  state_e          state, state_nxt;
  logic [XLEN-1:0] epc_q, cause_q;
  logic [XLEN-1:0] mstatus_new;
  upd_mode_e       upd_mode;

`ifdef CSR_TVAL_EN
  logic [XLEN-1:0] tval_q;
`else
  logic unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  assign upd_mode = (state == ST_M_STATUS) ? UPD_MRET : UPD_TRAP;

  csr_mstatus_upd #(.XLEN(XLEN)) u_mstatus_upd (
    .mstatus     (mstatus_rdata),
    .mode        (upd_mode),
    .mstatus_upd (mstatus_new)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
`ifdef CSR_TVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && trap_req) begin
        epc_q   <= trap_epc;
        cause_q <= trap_cause;
`ifdef CSR_TVAL_EN
        tval_q  <= trap_tval;
`endif
      end
    end
  end

  assign ex_stall = (state != ST_IDLE);

  // Outputs are forced low while reset is held, including the IDLE passthrough.
  always_comb begin
    state_nxt      = state;
    trap_ack       = 1'b0;
    mret_ack       = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          csr_we    = ex_csr_we;
          csr_waddr = ex_csr_waddr;
          csr_wdata = ex_csr_wdata;
          if (trap_req) begin
            trap_ack  = 1'b1;
            state_nxt = ST_T_EPC;
          end else if (mret_req) begin
            mret_ack  = 1'b1;
            state_nxt = ST_M_STATUS;
          end
        end
        ST_T_EPC: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = {epc_q[XLEN-1:1], 1'b0};
          state_nxt = ST_T_CAUSE;
        end
        ST_T_CAUSE: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
`ifdef CSR_TVAL_EN
          state_nxt = ST_T_TVAL;
`else
          state_nxt = ST_T_STATUS;
`endif
        end
`ifdef CSR_TVAL_EN
        ST_T_TVAL: begin
          csr_we    = 1'b1;
          csr_waddr = CSR_MTVAL;
          csr_wdata = tval_q;
          state_nxt = ST_T_STATUS;
        end
`endif
        ST_T_STATUS: begin
          csr_we         = 1'b1;
          csr_waddr      = CSR_MSTATUS;
          csr_wdata      = mstatus_new;
          redirect_valid = 1'b1;
          redirect_pc    = mtvec_rdata & MTVEC_KEEP;
          state_nxt      = ST_IDLE;
        end
        ST_M_STATUS: begin
          csr_we         = 1'b1;
          csr_waddr      = CSR_MSTATUS;
          csr_wdata      = mstatus_new;
          redirect_valid = 1'b1;
          redirect_pc    = mepc_rdata;
          state_nxt      = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
